// File: rtl/ysyx_25020047_dmem_responder.sv
// Data-memory responder: serves lw/lbu/lb/sw/sb from the execute stage against an
// internal word-organised SRAM. One transaction at a time, fixed access latency,
// valid/ready handshakes on both the request and the response channel.
`timescale 1ns/1ps

module ysyx_25020047_dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Byte span covered by the SRAM; anything at or beyond it (after rebasing) is out of range.
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [1:0]  state;
  logic [3:0]  cnt;

  // Request fields captured at accept; they stay put for the whole transaction.
  logic        cap_wen;
  logic [1:0]  cap_size;
  logic        cap_sext;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  // Address decode of the captured request.
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             size_ok;
  logic             in_range;
  logic             aligned;
  logic             acc_err;
  logic             access_fire;

  // Store byte lanes and the data each lane would receive.
  logic [3:0]       lane_sel;
  logic [3:0]       byte_we;
  logic [3:0][7:0]  wbyte;

  // Load path.
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [31:0] load_val;
  logic [31:0] rsp_value;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == ST_IDLE);

  // Rebasing with plain 32-bit subtraction makes addresses below ADDR_BASE wrap to huge
  // offsets, so a single compare against SPAN catches both underflow and overflow.
  assign off      = cap_addr - ADDR_BASE;
  assign idx      = off[IDX_W+1:2];
  assign lane     = off[1:0];
  assign size_ok  = (cap_size == SIZE_BYTE) || (cap_size == SIZE_WORD);
  assign in_range = (off < SPAN);
  assign aligned  = (cap_size != SIZE_WORD) || (lane == 2'b00);
  assign acc_err  = !(size_ok && in_range && aligned);

  // The single cycle in which the SRAM is touched and the response is registered.
  assign access_fire = (state == ST_BUSY) && (cnt == LAT);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Word stores hit all four lanes; byte stores only the addressed one, replicating wdata[7:0].
      assign lane_sel[gi] = (cap_size == SIZE_WORD) || (lane == 2'(gi));
      assign wbyte[gi]    = (cap_size == SIZE_WORD) ? cap_wdata[8*gi +: 8] : cap_wdata[7:0];
      assign byte_we[gi]  = access_fire && cap_wen && !acc_err && lane_sel[gi];
    end
  endgenerate

  assign rd_word = mem[idx];

  // Pick the addressed byte out of the read word.
  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  // Format the load result; stores and faulting accesses return zero.
  always_comb begin
    load_val = rd_word;
    if (cap_size != SIZE_WORD) begin
      load_val = {{24{cap_sext & rd_byte[7]}}, rd_byte};
    end
    rsp_value = (cap_wen || acc_err) ? 32'd0 : load_val;
  end

  // SRAM write port with per-byte enables; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) begin
        mem[idx][8*i +: 8] <= wbyte[i];
      end
    end
  end

  // Latch the request fields when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_wen   <= 1'b0;
      cap_size  <= SIZE_WORD;
      cap_sext  <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
    end else if ((state == ST_IDLE) && req_valid) begin
      cap_wen   <= req_wen;
      cap_size  <= req_size;
      cap_sext  <= req_sext;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Transaction sequencer: IDLE accepts, BUSY counts out the latency, RESP holds until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state <= ST_BUSY;
            cnt   <= 4'd1;
          end
        end
        ST_BUSY: begin
          if (cnt == LAT) begin
            state     <= ST_RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_value;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= 4'd0;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_dmem_responder.sv
// Bench for the data-memory responder: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a byte-addressed reference memory.
`timescale 1ns/1ps

module tb_ysyx_25020047_dmem_responder;

  localparam logic [31:0] ADDR_BASE = 32'h8000_0000;
  localparam int          DEPTH     = 1024;
  localparam int          LAT       = 2;
  localparam logic [31:0] WIN       = ADDR_BASE + 32'h100;
  localparam logic [31:0] TOP       = ADDR_BASE + 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: hold low

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk;
    int          acc;
    logic [31:0] addr;
    bit          wen;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_bytes [longint];

  ysyx_25020047_dmem_responder #(
    .ADDR_BASE  (ADDR_BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: byte-addressed memory, signed offset from the base.
  task automatic record(input bit wen, input logic [1:0] size, input bit sext,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    longint      off;
    int          n;
    int          v;
    logic [31:0] w;
    off = longint'(addr) - longint'(ADDR_BASE);
    n = (size == 2'b10) ? 4 : 1;
    w = 32'd0;
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.chk   = 1'b1;
    e.acc   = cyc;
    e.addr  = addr;
    e.wen   = wen;
    if (size == 2'b01 || size == 2'b11) begin
      e.err = 1'b1;
    end else if (off < 0 || off >= longint'(4 * DEPTH)) begin
      e.err = 1'b1;
    end else if (n == 4 && (off % 4) != 0) begin
      e.err = 1'b1;
    end else if (wen) begin
      for (int i = 0; i < n; i++) ref_bytes[off + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) begin
        if (ref_bytes.exists(off + i)) w[8*i +: 8] = ref_bytes[off + i];
        else e.chk = 1'b0;
      end
      if (n == 4) begin
        e.rdata = w;
      end else begin
        v = int'(w[7:0]);
        if (sext && v >= 128) v = v - 256;
        e.rdata = 32'(v);
      end
    end
    sb.push_back(e);
  endtask

  task automatic issue(input bit wen, input logic [1:0] size, input bit sext,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit expect_rsp);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_size  = size;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (expect_rsp) record(wen, size, sext, addr, wdata);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || rsp_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Response-side backpressure, changed just after each rising edge.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on first valid cycle, stability while stalled, payload on handshake.
  initial begin
    bit          prev_v;
    logic [31:0] prev_d;
    logic        prev_e;
    exp_t        e;
    prev_v = 1'b0;
    prev_d = 32'd0;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) check("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          else check("latency", 32'(cyc - sb[0].acc), 32'(LAT));
        end else begin
          check("hold_rdata", rsp_rdata, prev_d);
          check("hold_err", {31'd0, rsp_err}, {31'd0, prev_e});
        end
        if (rsp_ready && sb.size() != 0) begin
          e = sb.pop_front();
          $display("rsp %s addr=%h rdata=%h err=%0d", e.wen ? "st" : "ld", e.addr, rsp_rdata, rsp_err);
          if (e.chk) check("rdata", rsp_rdata, e.rdata);
          check("err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
      prev_v = rsp_valid;
      prev_d = rsp_rdata;
      prev_e = rsp_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_d;
    int          waited;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_size  = 2'b10;
    req_sext  = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Give every location the bench later reads a known value.
    issue(1'b1, 2'b10, 1'b0, ADDR_BASE + 32'h20, 32'hA5A5_0F0F, 1'b1);
    issue(1'b1, 2'b10, 1'b0, TOP - 32'd4, 32'h0BAD_F00D, 1'b1);
    for (int i = 0; i < 16; i++) issue(1'b1, 2'b10, 1'b0, WIN + 32'(4 * i), $urandom, 1'b1);

    // Word store then load
    issue(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 1'b1);

    // Byte store, zero/sign-extended byte loads, merged word
    issue(1'b1, 2'b00, 1'b0, 32'h8000_0011, 32'h0000_0080, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h8000_0011, 32'd0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h8000_0011, 32'd0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 1'b1);

    // Misaligned word accesses leave memory untouched
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0012, 32'd0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h8000_0012, 32'hFFFF_FFFF, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 1'b1);

    // Range edges and illegal sizes
    issue(1'b0, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'd0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, TOP, 32'd0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, TOP - 32'd4, 32'd0, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h8000_0010, 32'd0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h8000_0010, 32'h1111_1111, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 1'b1);
    drain();

    // Backpressure: response held for 5 cycles, second request waits
    ready_mode = 2;
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 1'b1);
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("stall_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    hold_d = rsp_rdata;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_size  = 2'b00;
    req_sext  = 1'b1;
    req_addr  = 32'h8000_0011;
    req_wdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, hold_d);
      @(negedge clk);
    end
    ready_mode = 0;
    waited = 0;
    while (rsp_valid && waited < 10) begin
      check("stall_release_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      waited++;
    end
    check("bubble_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    record(1'b0, 2'b00, 1'b1, 32'h8000_0011, 32'd0);
    req_valid = 1'b0;
    drain();

    // Reset in BUSY before the access cycle drops the store
    issue(1'b1, 2'b10, 1'b0, 32'h8000_0020, 32'h1234_5678, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'd0, 1'b1);
    drain();

    // Randomized traffic with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 250; t++) begin
      int          kind;
      bit          wen;
      bit          sext;
      logic [1:0]  sz;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      wen  = 1'($urandom_range(0, 1));
      sext = 1'($urandom_range(0, 1));
      sz   = 2'b10;
      a    = WIN;
      case (kind)
        0, 1, 2: a = WIN + 32'(4 * $urandom_range(0, 15));
        3, 4, 5: begin sz = 2'b00; a = WIN + 32'($urandom_range(0, 63)); end
        6:       a = WIN + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        7: begin
          sz = $urandom_range(0, 1) ? 2'b10 : 2'b00;
          if ($urandom_range(0, 1) == 1) a = ADDR_BASE - 32'(4 * $urandom_range(1, 8));
          else a = TOP + 32'($urandom_range(0, 31));
        end
        8: begin
          sz = $urandom_range(0, 1) ? 2'b01 : 2'b11;
          a  = WIN + 32'($urandom_range(0, 63));
        end
        default: begin sz = 2'b00; a = TOP - 32'($urandom_range(1, 4)); end
      endcase
      issue(wen, sz, sext, a, $urandom, 1'b1);
    end
    ready_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
